if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RISC-V core. Sits directly upstream of the decode stage.
- Owns the architectural fetch PC and selects the next PC from sequential, decode-predicted and execute-resolved sources.
- Drives the synchronous-read BIOS and IMEM ports so that instruction data arrives in the cycle where if_pc is valid.
- Provides boot sequencing, stall hold, misalignment detection and fetch/redirect performance counters.

---
 rtl/if_stage.sv | 103 ++++++++++
 tb/tb_if_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives the BIOS/IMEM read ports
// and keeps boot sequencing, misalignment and performance counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter int          BIOS_AW  = 12,
    parameter int          IMEM_AW  = 14,
    parameter int          CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_stall,
    input  logic               ex_flush,
    input  logic [31:0]        ex_pc_target,
    input  logic               id_target_taken,
    input  logic [31:0]        id_pc_target,
    output logic [31:0]        if_pc,
    output logic               if_valid,
    output logic [BIOS_AW-1:0] bios_addr,
    output logic               bios_en,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic               imem_en,
    output logic               misalign_err,
    output logic [CNT_W-1:0]   fetch_count,
    output logic [CNT_W-1:0]   redirect_count
);

    localparam logic [0:0] BOOT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]  state;
    logic [31:0] next_pc;
    logic        run;
    logic        flush_acc;
    logic        id_acc;
    logic        redir_acc;
    logic        fetch_acc;
    logic        mis_set;

    assign run       = (state == RUN);
    assign flush_acc = run & ex_flush;
    // A held decode instruction cannot redirect; only flush overrides a stall.
    assign id_acc    = run & ~ex_flush & ~ex_stall & id_target_taken;
    assign redir_acc = flush_acc | id_acc;
    assign fetch_acc = if_valid & (~ex_stall | ex_flush);
    assign mis_set   = (flush_acc & (|ex_pc_target[1:0]))
                     | (id_acc & (|id_pc_target[1:0]));

    always_comb begin
        next_pc = if_pc + 32'd4;
        if (!run) begin
            next_pc = RESET_PC;
        end else if (ex_flush) begin
            next_pc = {ex_pc_target[31:2], 2'b00};
        end else if (ex_stall) begin
            next_pc = if_pc;
        end else if (id_target_taken) begin
            next_pc = {id_pc_target[31:2], 2'b00};
        end
    end

    // Memories register the address, so data lines up with if_pc next cycle.
    assign bios_addr = next_pc[BIOS_AW+1:2];
    assign imem_addr = next_pc[IMEM_AW+1:2];
    assign bios_en   = next_pc[30];
    assign imem_en   = ~next_pc[30];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            if_pc    <= RESET_PC;
            if_valid <= 1'b0;
        end else begin
            state    <= RUN;
            if_pc    <= next_pc;
            if_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else if (mis_set) begin
            misalign_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (fetch_acc && fetch_count != {CNT_W{1'b1}}) begin
            fetch_count <= fetch_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_count <= '0;
        end else if (redir_acc && redirect_count != {CNT_W{1'b1}}) begin
            redirect_count <= redirect_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios then random traffic against
// a cycle-level reference model of the fetch PC and counters.
module tb_if_stage;

    localparam logic [31:0] RPC = 32'h4000_0000;

    logic        clk;
    logic        rst_n;
    logic        ex_stall;
    logic        ex_flush;
    logic [31:0] ex_pc_target;
    logic        id_target_taken;
    logic [31:0] id_pc_target;
    logic [31:0] if_pc;
    logic        if_valid;
    logic [11:0] bios_addr;
    logic        bios_en;
    logic [13:0] imem_addr;
    logic        imem_en;
    logic        misalign_err;
    logic [31:0] fetch_count;
    logic [31:0] redirect_count;

    int n_cmp;
    int n_bad;

    logic        m_boot;
    logic        m_valid;
    logic        m_mis;
    logic [31:0] m_pc;
    logic [31:0] m_fc;
    logic [31:0] m_rc;

    if_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_stall       (ex_stall),
        .ex_flush       (ex_flush),
        .ex_pc_target   (ex_pc_target),
        .id_target_taken(id_target_taken),
        .id_pc_target   (id_pc_target),
        .if_pc          (if_pc),
        .if_valid       (if_valid),
        .bios_addr      (bios_addr),
        .bios_en        (bios_en),
        .imem_addr      (imem_addr),
        .imem_en        (imem_en),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count),
        .redirect_count (redirect_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state();
        chk("if_pc", if_pc, m_pc);
        chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
        chk("misalign", {31'd0, misalign_err}, {31'd0, m_mis});
        chk("fetch_cnt", fetch_count, m_fc);
        chk("redir_cnt", redirect_count, m_rc);
    endtask

    task automatic model_reset();
        m_boot  = 1'b1;
        m_valid = 1'b0;
        m_mis   = 1'b0;
        m_pc    = RPC;
        m_fc    = 0;
        m_rc    = 0;
    endtask

    // One clock: apply inputs, check the address presented, then the result.
    task automatic step(input logic f, input logic s, input logic t,
                        input logic [31:0] ft, input logic [31:0] it);
        logic [31:0] npc;
        logic        redir;
        ex_flush        = f;
        ex_stall        = s;
        id_target_taken = t;
        ex_pc_target    = ft;
        id_pc_target    = it;
        redir = 1'b0;
        if (m_boot) npc = RPC;
        else if (f) begin
            npc = ft & ~32'd3;
            redir = 1'b1;
            if (ft % 4 != 0) m_mis = 1'b1;
        end else if (s) npc = m_pc;
        else if (t) begin
            npc = it & ~32'd3;
            redir = 1'b1;
            if (it % 4 != 0) m_mis = 1'b1;
        end else npc = m_pc + 4;
        #1;
        chk("bios_addr", {20'd0, bios_addr}, (npc / 4) % 4096);
        chk("imem_addr", {18'd0, imem_addr}, (npc / 4) % 16384);
        chk("bios_en", {31'd0, bios_en}, {31'd0, npc[30]});
        chk("imem_en", {31'd0, imem_en}, {31'd0, !npc[30]});
        @(posedge clk);
        #1;
        if (m_valid && (!s || f) && m_fc != 32'hFFFF_FFFF) m_fc++;
        if (redir && m_rc != 32'hFFFF_FFFF) m_rc++;
        m_pc    = npc;
        m_valid = 1'b1;
        m_boot  = 1'b0;
        chk_state();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_state();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        ex_flush = 0; ex_stall = 0; id_target_taken = 0;
        ex_pc_target = 0; id_pc_target = 0;
        rst_n = 1'b0;
        model_reset();
        #12;
        chk_state();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        // Boot then straight-line fetch up to 4000_0008
        idle(3);
        chk("s1_pc", if_pc, 32'h4000_0008);
        // Three-cycle stall holds PC
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        chk("s2_hold", if_pc, 32'h4000_0008);
        idle(1);
        chk("s2_rel", if_pc, 32'h4000_000C);
        // Decode-predicted redirect into IMEM
        step(0, 0, 1, 0, 32'h0000_0100);
        chk("s3_pc", if_pc, 32'h0000_0100);
        // Flush beats stall and decode redirect
        step(1, 1, 1, 32'h0000_0200, 32'h0000_0300);
        chk("s4_pc", if_pc, 32'h0000_0200);
        // Stall suppresses decode redirect
        step(0, 1, 1, 0, 32'h0000_0300);
        // Misaligned flush target
        step(1, 0, 0, 32'h0000_0203, 0);
        chk("s5_pc", if_pc, 32'h0000_0200);
        idle(10);
        chk("s5_sticky", {31'd0, misalign_err}, 32'd1);
        // PC wraps at the top of the address space
        step(0, 0, 1, 0, 32'hFFFF_FFFE);
        idle(2);
        chk("wrap", if_pc, 32'h0000_0004);
        step(0, 0, 1, 0, 32'h0000_0100);
        idle(1);
        pulse_reset();
        idle(4);
        // Random traffic, with a mid-run reset
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ft;
            logic [31:0] it;
            ft = $urandom;
            it = $urandom;
            if ($urandom_range(3) != 0) ft[1:0] = 2'b00;
            if ($urandom_range(3) != 0) it[1:0] = 2'b00;
            step($urandom_range(7) == 0, $urandom_range(3) == 0,
                 $urandom_range(3) == 0, ft, it);
            if (i == 200) pulse_reset();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
